vend_ctrl_multi: RTL and testbench
==================================

Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-price 10-unit vending controller.
- Accepts 1/2/5-unit coins into a saturating credit register and supports NUM_ITEMS products with individual prices.
- Dispenses a vend request over a ready/ack handshake, then returns change one coin per handshake using greedy 5/2/1 selection.
- Exports credit as two BCD digits for the existing 7-segment multiplexer; sits between the button/coin debouncers and the display/LED drivers.

Parameters:
- CREDIT_W, 7, credit register width in bits; must satisfy 2^CREDIT_W > MAX_CREDIT.
- MAX_CREDIT, 99, largest credit accepted; at most 99 so two BCD digits suffice.
- NUM_ITEMS, 4, number of selectable products.
- PRICES, {7'd25,7'd20,7'd15,7'd10}, packed per-item prices, CREDIT_W bits each; item i occupies bits [i*CREDIT_W +: CREDIT_W]; each price must be nonzero and at most MAX_CREDIT.
- TIMEOUT, 1000, vend-ack timeout in clk cycles; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- r1, r2, r5  in  1 each  coin-sensor levels (already debounced); a coin is a rising edge.
- sel  in  NUM_ITEMS  product buttons, level; the lowest set index wins.
- cancel  in  1  refund request, level.
- credit  out  CREDIT_W  current credit, binary.
- bcd_tens, bcd_ones  out  4 each  credit as BCD, registered.
- coin_reject  out  1  one-cycle pulse: a coin edge was refused.
- low_credit  out  1  one-cycle pulse: a selection was refused.
- vend_valid  out  1  vend request, held until acknowledged.
- vend_item  out  $clog2(NUM_ITEMS)  index of the item being vended; stable while vend_valid is high.
- vend_ack  in  1  dispenser acknowledge.
- chg_valid  out  1  change-coin request, held until acknowledged.
- chg_coin  out  2  coin code: 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- chg_ack  in  1  change-hopper acknowledge.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; credit=0; BCD digits=0; all pulse and valid outputs 0; vend_item=0; chg_coin=00; edge-detect registers cleared to 0.
- Coin edge detection: sample r1/r2/r5 into previous-value registers each clk; edge = current & ~previous.
- Simultaneous coin edges: accept only the highest denomination (r5, then r2, then r1); pulse coin_reject once for the dropped edges.
- IDLE: credit is 0. An accepted coin adds its value and moves to COLLECT in the same cycle.
- COLLECT, coins: if credit + value > MAX_CREDIT, reject the coin (coin_reject, credit unchanged). Otherwise credit updates on the next edge of clk.
- COLLECT, selection and cancel, priority cancel > sel > coin in one cycle:
  - cancel: go to CHANGE with credit unchanged.
  - sel with credit >= price: latch vend_item, credit <= credit - price, enter VEND, assert vend_valid on the next cycle.
  - sel with credit < price: pulse low_credit, stay in COLLECT.
  - Any coin edge arriving in the same cycle as an accepted cancel or sel is rejected.
- VEND: vend_valid stays high until the cycle vend_ack=1 is sampled; vend_valid drops the following cycle.
  - On ack: go to CHANGE if credit > 0, else IDLE.
  - vend_ack while vend_valid=0 is ignored.
- CHANGE: if credit = 0, go to IDLE. Otherwise assert chg_valid with chg_coin = largest of 5/2/1 not exceeding credit.
  - On chg_ack: credit decreases by that coin value; chg_valid drops for one cycle before the next coin is presented.
  - Example: credit 8 gives coins 5, 2, 1, then IDLE.
- In VEND and CHANGE: all coin edges are rejected; sel and cancel are ignored.
- BCD digits: registered from credit, one cycle of latency; values above 99 are impossible by construction.
- Reset mid-operation: everything returns to IDLE with credit=0; in-flight credit is forfeited and no change is issued.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined: a counter runs while vend_valid=1. If it reaches TIMEOUT without vend_ack:
  - restore the item price to credit;
  - pulse vend_fault (extra 1-bit output, present only when the macro is defined);
  - drop vend_valid and go to CHANGE, refunding the full credit.
  - The counter clears on entry to VEND.
- Not defined: VEND waits for vend_ack indefinitely; no counter and no vend_fault port.

Test Plan:
- Reset release, then coins r5, r5, r5, r2 -> credit 5, 10, 15, 17; bcd_tens/bcd_ones = 1/7 one cycle after the last credit update.
- Credit 17, sel[0] (price 10) -> vend_valid with vend_item=0, credit 7; ack after 3 cycles -> change coins 5 then 2, each held until chg_ack; ends in IDLE with credit 0.
- Credit 12, sel[3] (price 25) -> one low_credit pulse, credit stays 12, state stays COLLECT; then cancel -> change coins 5, 5, 2.
- Credit 97, r5 -> coin_reject, credit stays 97; r2 -> credit 99; r1 -> coin_reject.
- r1, r2, r5 rising in the same cycle from credit 0 -> credit 5 and one coin_reject pulse; a coin edge during VEND -> coin_reject, credit unchanged.
- Reset pulled low while chg_valid=1 at credit 6 -> all outputs return to reset values immediately. With VEND_TIMEOUT_EN and TIMEOUT=20, no vend_ack -> vend_fault at cycle 20 and the full refund is issued as change.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller.
// Coins (1/2/5 units) accumulate into a saturating credit register. A product
// button vends the lowest selected item over a valid/ack handshake, and any
// remaining credit is returned one coin per handshake using greedy 5/2/1 selection.
// Credit is also exported as two registered BCD digits for the display.
// Optional feature macro: VEND_TIMEOUT_EN. When it is defined, a vend that is not
// acknowledged within TIMEOUT cycles is aborted, the item price is refunded, and
// vend_fault pulses.
module vend_ctrl_multi #(
    parameter int                            CREDIT_W   = 7,
    parameter int                            MAX_CREDIT = 99,
    parameter int                            NUM_ITEMS  = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {7'd25, 7'd20, 7'd15, 7'd10},
    parameter int                            TIMEOUT    = 1000,
    parameter int                            ITEM_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r1,
    input  logic                 r2,
    input  logic                 r5,
    input  logic [NUM_ITEMS-1:0] sel,
    input  logic                 cancel,
    output logic [CREDIT_W-1:0]  credit,
    output logic [3:0]           bcd_tens,
    output logic [3:0]           bcd_ones,
    output logic                 coin_reject,
    output logic                 low_credit,
    output logic                 vend_valid,
    output logic [ITEM_W-1:0]    vend_item,
    input  logic                 vend_ack,
    output logic                 chg_valid,
    output logic [1:0]           chg_coin,
    input  logic                 chg_ack,
    output logic                 busy
`ifdef VEND_TIMEOUT_EN
    ,
    output logic                 vend_fault
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [3:0]          bcd_tens_reg, bcd_tens_next;
    logic [3:0]          bcd_ones_reg, bcd_ones_next;
    logic                r1_prev_reg, r2_prev_reg, r5_prev_reg;
    logic                coin_reject_reg, coin_reject_next;
    logic                low_credit_reg, low_credit_next;
    logic                vend_valid_reg, vend_valid_next;
    logic [ITEM_W-1:0]   vend_item_reg, vend_item_next;
    logic                chg_valid_reg, chg_valid_next;
    logic [1:0]          chg_coin_reg, chg_coin_next;

    // Unpacked view of the per-item price table.
    logic [CREDIT_W-1:0] price_arr [NUM_ITEMS];

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
            assign price_arr[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    // Coin edges, the single accepted denomination, and whether it still fits.
    logic                e1, e2, e5;
    logic                coin_any, coin_multi, coin_fits;
    logic [CREDIT_W-1:0] coin_val;

    // Decode coin edges; the highest denomination wins and the rest are dropped.
    always_comb begin
        e1         = r1 & ~r1_prev_reg;
        e2         = r2 & ~r2_prev_reg;
        e5         = r5 & ~r5_prev_reg;
        coin_any   = e1 | e2 | e5;
        coin_multi = (e5 & (e2 | e1)) | (e2 & e1);
        coin_val   = '0;
        if (e5) begin
            coin_val = CREDIT_W'(5);
        end else if (e2) begin
            coin_val = CREDIT_W'(2);
        end else if (e1) begin
            coin_val = CREDIT_W'(1);
        end
        coin_fits = ({1'b0, credit_reg} + {1'b0, coin_val}) <= (CREDIT_W+1)'(MAX_CREDIT);
    end

    // Selection: the lowest set button index wins.
    logic                sel_any;
    logic [ITEM_W-1:0]   sel_idx;
    logic [CREDIT_W-1:0] sel_price;

    // Priority-encode the product buttons and look up the chosen price.
    always_comb begin
        sel_any = |sel;
        sel_idx = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_idx = ITEM_W'(i);
            end
        end
        sel_price = price_arr[sel_idx];
    end

    // Greedy change choice and the value of the coin currently presented.
    logic [1:0]          greedy_code;
    logic [CREDIT_W-1:0] presented_val;

    // Pick the largest coin not exceeding credit; decode the presented coin.
    always_comb begin
        if (credit_reg >= CREDIT_W'(5)) begin
            greedy_code = 2'b11;
        end else if (credit_reg >= CREDIT_W'(2)) begin
            greedy_code = 2'b10;
        end else begin
            greedy_code = 2'b01;
        end
        case (chg_coin_reg)
            2'b11:   presented_val = CREDIT_W'(5);
            2'b10:   presented_val = CREDIT_W'(2);
            2'b01:   presented_val = CREDIT_W'(1);
            default: presented_val = '0;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic            vend_fault_reg, vend_fault_next;
    logic            timeout_hit;
    assign timeout_hit = vend_valid_reg && (timeout_cnt_reg == TO_W'(TIMEOUT - 1));
`endif

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_next       = state_reg;
        credit_next      = credit_reg;
        vend_item_next   = vend_item_reg;
        vend_valid_next  = vend_valid_reg;
        chg_valid_next   = chg_valid_reg;
        chg_coin_next    = chg_coin_reg;
        coin_reject_next = coin_multi;
        low_credit_next  = 1'b0;
`ifdef VEND_TIMEOUT_EN
        vend_fault_next  = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_next = credit_reg + coin_val;
                        state_next  = S_COLLECT;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_next       = S_CHANGE;
                    coin_reject_next = coin_any;
                end else if (sel_any && (credit_reg >= sel_price)) begin
                    credit_next      = credit_reg - sel_price;
                    vend_item_next   = sel_idx;
                    vend_valid_next  = 1'b1;
                    state_next       = S_VEND;
                    coin_reject_next = coin_any;
                end else begin
                    // A refused selection still lets a coin in this cycle.
                    low_credit_next = sel_any;
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit_next = credit_reg + coin_val;
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                coin_reject_next = coin_any;
                if (vend_valid_reg && vend_ack) begin
                    vend_valid_next = 1'b0;
                    state_next      = (credit_reg != '0) ? S_CHANGE : S_IDLE;
                end
`ifdef VEND_TIMEOUT_EN
                else if (timeout_hit) begin
                    credit_next     = credit_reg + price_arr[vend_item_reg];
                    vend_fault_next = 1'b1;
                    vend_valid_next = 1'b0;
                    state_next      = S_CHANGE;
                end
`endif
            end
            S_CHANGE: begin
                coin_reject_next = coin_any;
                if (chg_valid_reg) begin
                    if (chg_ack) begin
                        credit_next    = credit_reg - presented_val;
                        chg_valid_next = 1'b0;
                        chg_coin_next  = 2'b00;
                    end
                end else if (credit_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    chg_valid_next = 1'b1;
                    chg_coin_next  = greedy_code;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Binary-to-BCD split of the current credit (credit never exceeds 99).
    always_comb begin
        bcd_tens_next = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (credit_reg >= CREDIT_W'(10 * t)) begin
                bcd_tens_next = 4'(t);
            end
        end
        bcd_ones_next = 4'(credit_reg - CREDIT_W'(bcd_tens_next) * CREDIT_W'(10));
    end

    // State, credit and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            credit_reg      <= '0;
            bcd_tens_reg    <= 4'd0;
            bcd_ones_reg    <= 4'd0;
            coin_reject_reg <= 1'b0;
            low_credit_reg  <= 1'b0;
            vend_valid_reg  <= 1'b0;
            vend_item_reg   <= '0;
            chg_valid_reg   <= 1'b0;
            chg_coin_reg    <= 2'b00;
        end else begin
            state_reg       <= state_next;
            credit_reg      <= credit_next;
            bcd_tens_reg    <= bcd_tens_next;
            bcd_ones_reg    <= bcd_ones_next;
            coin_reject_reg <= coin_reject_next;
            low_credit_reg  <= low_credit_next;
            vend_valid_reg  <= vend_valid_next;
            vend_item_reg   <= vend_item_next;
            chg_valid_reg   <= chg_valid_next;
            chg_coin_reg    <= chg_coin_next;
        end
    end

    // Previous coin-sensor levels for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1_prev_reg <= 1'b0;
            r2_prev_reg <= 1'b0;
            r5_prev_reg <= 1'b0;
        end else begin
            r1_prev_reg <= r1;
            r2_prev_reg <= r2;
            r5_prev_reg <= r5;
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Clear the ack timeout on VEND entry, count while a vend is pending.
    always_comb begin
        timeout_cnt_next = timeout_cnt_reg;
        if (state_reg != S_VEND && state_next == S_VEND) begin
            timeout_cnt_next = '0;
        end else if (vend_valid_reg) begin
            timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
        end
    end

    // Timeout counter and fault pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_cnt_reg <= '0;
            vend_fault_reg  <= 1'b0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_next;
            vend_fault_reg  <= vend_fault_next;
        end
    end

    assign vend_fault = vend_fault_reg;
`endif

    assign credit      = credit_reg;
    assign bcd_tens    = bcd_tens_reg;
    assign bcd_ones    = bcd_ones_reg;
    assign coin_reject = coin_reject_reg;
    assign low_credit  = low_credit_reg;
    assign vend_valid  = vend_valid_reg;
    assign vend_item   = vend_item_reg;
    assign chg_valid   = chg_valid_reg;
    assign chg_coin    = chg_coin_reg;
    assign busy        = (state_reg == S_VEND) || (state_reg == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus pushes expected events
// (vend request, change coin, coin reject, low credit) into a queue; a monitor
// pops and compares them whenever the DUT presents one. Credit/BCD/busy values
// are also checked directly at hand-computed points.
module tb_vend_ctrl_multi;

    localparam int K_VEND = 0;
    localparam int K_CHG  = 1;
    localparam int K_REJ  = 2;
    localparam int K_LOW  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r1 = 1'b0, r2 = 1'b0, r5 = 1'b0;
    logic [3:0] sel = 4'b0000;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic [6:0] credit;
    logic [3:0] bcd_tens, bcd_ones;
    logic       coin_reject, low_credit, vend_valid, chg_valid, busy;
    logic [1:0] vend_item;
    logic [1:0] chg_coin;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    logic vv_prev = 1'b0;
    logic cv_prev = 1'b0;

    vend_ctrl_multi dut (
        .clk         (clk),
        .reset       (reset),
        .r1          (r1),
        .r2          (r2),
        .r5          (r5),
        .sel         (sel),
        .cancel      (cancel),
        .credit      (credit),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .coin_reject (coin_reject),
        .low_credit  (low_credit),
        .vend_valid  (vend_valid),
        .vend_item   (vend_item),
        .vend_ack    (vend_ack),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .chg_ack     (chg_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_VEND:  return "vend";
            K_CHG:   return "change";
            K_REJ:   return "coin_reject";
            default: return "low_credit";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        checks++;
        $display("event %s value %0d at %0t", kname(k), v, $time);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s/%0d, expected none", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event_order: got %s/%0d, expected %s/%0d",
                         kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge and score each presented event.
    always @(negedge clk) begin
        if (reset) begin
            if (vend_valid && !vv_prev) observe(K_VEND, int'(vend_item));
            if (chg_valid && !cv_prev)  observe(K_CHG, int'(chg_coin));
            if (coin_reject)            observe(K_REJ, 0);
            if (low_credit)             observe(K_LOW, 0);
        end
        vv_prev = vend_valid;
        cv_prev = chg_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        if (v == 5) r5 = 1'b1;
        else if (v == 2) r2 = 1'b1;
        else r1 = 1'b1;
        tick();
        r1 = 1'b0;
        r2 = 1'b0;
        r5 = 1'b0;
        tick();
    endtask

    task automatic serve_change(input int n);
        for (int i = 0; i < n; i++) begin
            int wait_cnt = 0;
            while (!chg_valid && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            if (!chg_valid) begin
                checks++;
                errors++;
                $display("FAIL chg_valid_timeout: coin %0d never presented", i);
                return;
            end
            chg_ack = 1'b1;
            tick();
            chg_ack = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_credit", credit, 0);
        check("reset_bcd", {bcd_tens, bcd_ones}, 0);
        check("reset_valids", {vend_valid, chg_valid, coin_reject, low_credit, busy}, 0);
        check("reset_codes", {vend_item, chg_coin}, 0);
        reset = 1'b1;
        tick();

        // Coins 5,5,5,2 -> 17
        coin(5); check("credit_5", credit, 5);
        coin(5); check("credit_10", credit, 10);
        coin(5); check("credit_15", credit, 15);
        coin(2); check("credit_17", credit, 17);
        check("bcd_17", {bcd_tens, bcd_ones}, 8'h17);

        // Vend item 0 (price 10), change 5 then 2
        push(K_VEND, 0);
        sel = 4'b0001;
        tick();
        sel = 4'b0000;
        check("vend_credit_7", credit, 7);
        check("vend_busy", busy, 1);
        repeat (3) tick();
        check("vend_still_valid", vend_valid, 1);
        push(K_CHG, 3);
        push(K_CHG, 2);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        serve_change(2);
        check("after_change_credit", credit, 0);
        check("after_change_busy", busy, 0);

        // Low credit on item 3, then cancel refund 5,5,2
        coin(5); coin(5); coin(2);
        check("credit_12", credit, 12);
        push(K_LOW, 0);
        sel = 4'b1000;
        tick();
        sel = 4'b0000;
        tick();
        check("low_credit_keeps", credit, 12);
        check("low_credit_not_busy", busy, 0);
        push(K_CHG, 3);
        push(K_CHG, 3);
        push(K_CHG, 2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        serve_change(3);
        check("cancel_credit", credit, 0);

        // Saturation near 99
        for (int i = 0; i < 19; i++) coin(5);
        coin(2);
        check("credit_97", credit, 97);
        push(K_REJ, 0);
        coin(5);
        check("reject_keeps_97", credit, 97);
        coin(2);
        check("credit_99", credit, 99);
        check("bcd_99", {bcd_tens, bcd_ones}, 8'h99);
        push(K_REJ, 0);
        coin(1);
        check("reject_keeps_99", credit, 99);
        for (int i = 0; i < 19; i++) push(K_CHG, 3);
        push(K_CHG, 2);
        push(K_CHG, 2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        serve_change(21);
        check("refund_99_credit", credit, 0);

        // Simultaneous coin edges, lowest-index selection, coin during VEND
        push(K_REJ, 0);
        r1 = 1'b1; r2 = 1'b1; r5 = 1'b1;
        tick();
        r1 = 1'b0; r2 = 1'b0; r5 = 1'b0;
        tick();
        check("multi_coin_credit", credit, 5);
        coin(5); coin(5);
        push(K_VEND, 1);
        sel = 4'b0110;
        tick();
        sel = 4'b0000;
        check("vend_item1_credit", credit, 0);
        push(K_REJ, 0);
        coin(2);
        check("vend_coin_ignored", credit, 0);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        tick();
        check("vend_done_valid", vend_valid, 0);
        check("vend_done_idle", busy, 0);

        // Reset while a change coin is presented at credit 6
        coin(5); coin(1);
        check("credit_6", credit, 6);
        push(K_CHG, 3);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        repeat (3) tick();
        check("chg_valid_before_reset", chg_valid, 1);
        reset = 1'b0;
        #1;
        check("midreset_credit", credit, 0);
        check("midreset_outputs", {chg_valid, vend_valid, busy, chg_coin}, 0);
        check("midreset_bcd", {bcd_tens, bcd_ones}, 0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("post_reset_idle", {busy, chg_valid, credit}, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
